// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_pkg.sv
// Shared types and constants for the March C- BIST sequencer.
package arf062b064e1r1w0cbbehsaa4acw_bist_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StW0Up,
    StR0W1Up,
    StR1W0Up,
    StR0W1Dn,
    StR1W0Dn,
    StR0Dn,
    StDrain,
    StDone
  } bist_state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t ElemW0U   = 3'd0;
  localparam elem_t ElemR0W1U = 3'd1;
  localparam elem_t ElemR1W0U = 3'd2;
  localparam elem_t ElemR0W1D = 3'd3;
  localparam elem_t ElemR1W0D = 3'd4;
  localparam elem_t ElemR0D   = 3'd5;

  // Background patterns are all-0 or all-1, so one polarity bit describes a whole word.
  localparam logic PatAll0 = 1'b0;
  localparam logic PatAll1 = 1'b1;

  function automatic elem_t state_elem(input bist_state_t s);
    case (s)
      StR0W1Up: return ElemR0W1U;
      StR1W0Up: return ElemR1W0U;
      StR0W1Dn: return ElemR0W1D;
      StR1W0Dn: return ElemR1W0D;
      StR0Dn:   return ElemR0D;
      default:  return ElemW0U;
    endcase
  endfunction

  // Value a read in this element expects.
  function automatic logic state_rd_pol(input bist_state_t s);
    return (s == StR1W0Up || s == StR1W0Dn) ? PatAll1 : PatAll0;
  endfunction

  // Value the write phase of this element stores.
  function automatic logic state_wr_pol(input bist_state_t s);
    return (s == StR0W1Up || s == StR0W1Dn) ? PatAll1 : PatAll0;
  endfunction

  function automatic logic state_is_dn(input bist_state_t s);
    return (s == StR0W1Dn || s == StR1W0Dn || s == StR0Dn);
  endfunction

  // Read/write element that follows a completed read/write element.
  function automatic bist_state_t next_elem(input bist_state_t s);
    case (s)
      StR0W1Up: return StR1W0Up;
      StR1W0Up: return StR0W1Dn;
      StR0W1Dn: return StR1W0Dn;
      default:  return StR0Dn;
    endcase
  endfunction

endpackage

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_addr_cnt.sv
// Up/down BIST address counter with clear, load-to-start and terminal count.
module arf062b064e1r1w0cbbehsaa4acw_bist_addr_cnt #(
  parameter int unsigned NUM_ENTRIES = 62,
  parameter int unsigned ADDR_W      = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              load_dn_i,
  input  logic              en_i,
  input  logic              dn_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              tc_o
);

  localparam logic [ADDR_W-1:0] Last = ADDR_W'(NUM_ENTRIES - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Clear beats load beats step; a load picks the start address of the new direction.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_dn_i ? Last : '0;
    end else if (en_i) begin
      cnt_d = dn_i ? cnt_q - 1'b1 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = dn_i ? (cnt_q == '0) : (cnt_q == Last);

endmodule

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_march_seq.sv
// March C- BIST sequencer for the 1R1W array.
// Optional first-fail capture ports are built when
// ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN is defined.
module arf062b064e1r1w0cbbehsaa4acw_bist_march_seq
  import arf062b064e1r1w0cbbehsaa4acw_bist_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 62,
  parameter int unsigned ADDR_W      = $clog2(NUM_ENTRIES),
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bist_start,
  input  logic [DATA_W-1:0] bist_rd_data,
  output logic [ADDR_W-1:0] bist_addr,
  output logic              bist_wr_en,
  output logic              bist_rd_en,
  output logic [DATA_W-1:0] bist_wdata,
  output logic              bist_busy,
  output logic              bist_done,
`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic [2:0]        bist_fail_elem,
`endif
  output logic              bist_fail
);

  bist_state_t       state_q, state_d;
  logic              phase_q, phase_d;  // 0: read phase, 1: write phase of an RxWy element
  logic [2:0]        drain_q, drain_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic              wpol, start_acc, miss;
  logic              cnt_clr, cnt_load, cnt_load_dn, cnt_en, cnt_tc;

  // Compare pipeline: valid and expected polarity per read in flight.
  logic [RD_LAT-1:0] pv_q, pv_d, pp_q, pp_d;

  arf062b064e1r1w0cbbehsaa4acw_bist_addr_cnt #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .ADDR_W     (ADDR_W)
  ) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .load_i   (cnt_load),
    .load_dn_i(cnt_load_dn),
    .en_i     (cnt_en),
    .dn_i     (state_is_dn(state_q)),
    .cnt_o    (bist_addr),
    .tc_o     (cnt_tc)
  );

  assign miss = pv_q[RD_LAT-1] && (bist_rd_data != {DATA_W{pp_q[RD_LAT-1]}});

  // Next operation and the registered array controls that present it.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    drain_d     = drain_q;
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    cnt_load_dn = 1'b0;
    cnt_en      = 1'b0;
    start_acc   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bist_start) begin
          state_d   = StW0Up;
          phase_d   = 1'b0;
          cnt_load  = 1'b1;
          start_acc = 1'b1;
        end
      end
      StW0Up: begin
        if (cnt_tc) begin
          state_d  = StR0W1Up;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StR0W1Up, StR1W0Up, StR0W1Dn, StR1W0Dn: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (cnt_tc) begin
            state_d     = next_elem(state_q);
            cnt_load    = 1'b1;
            cnt_load_dn = state_is_dn(state_d);
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      StR0Dn: begin
        if (cnt_tc) begin
          state_d = StDrain;
          cnt_clr = 1'b1;
          drain_d = '0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 3'(RD_LAT - 1)) state_d = StDone;
        else                           drain_d = drain_q + 3'd1;
      end
      default: state_d = StIdle;
    endcase

    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    wpol    = PatAll0;
    unique case (state_d)
      StW0Up: wr_en_d = 1'b1;
      StR0W1Up, StR1W0Up, StR0W1Dn, StR1W0Dn: begin
        if (!phase_d) begin
          rd_en_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          wpol    = state_wr_pol(state_d);
        end
      end
      StR0Dn:  rd_en_d = 1'b1;
      default: ;
    endcase
    wdata_d = {DATA_W{wpol & wr_en_d}};
    busy_d  = !(state_d == StIdle || state_d == StDone);
    done_d  = (state_d == StDone);
    fail_d  = start_acc ? 1'b0 : (fail_q | miss);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
      drain_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  // Shift the read currently on the array into the compare pipeline.
  always_comb begin
    pv_d    = pv_q;
    pp_d    = pp_q;
    pv_d[0] = rd_en_q;
    pp_d[0] = state_rd_pol(state_q);
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pp_d[i] = pp_q[i-1];
    end
  end

  // Compare pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      pp_q <= '0;
    end else begin
      pv_q <= pv_d;
      pp_q <= pp_d;
    end
  end

`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN
  logic [ADDR_W-1:0] pa_q [RD_LAT];
  elem_t             pe_q [RD_LAT];
  logic [ADDR_W-1:0] fail_addr_q;
  elem_t             fail_elem_q;

  // Carry address/element with each read; latch only the first miscompare of a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pa_q[i] <= '0;
        pe_q[i] <= ElemW0U;
      end
      fail_addr_q <= '0;
      fail_elem_q <= ElemW0U;
    end else begin
      pa_q[0] <= bist_addr;
      pe_q[0] <= state_elem(state_q);
      for (int i = 1; i < RD_LAT; i++) begin
        pa_q[i] <= pa_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
      if (start_acc) begin
        fail_addr_q <= '0;
        fail_elem_q <= ElemW0U;
      end else if (miss && !fail_q) begin
        fail_addr_q <= pa_q[RD_LAT-1];
        fail_elem_q <= pe_q[RD_LAT-1];
      end
    end
  end

  assign bist_fail_addr = fail_addr_q;
  assign bist_fail_elem = fail_elem_q;
`endif

  assign bist_rd_en = rd_en_q;
  assign bist_wr_en = wr_en_q;
  assign bist_wdata = wdata_q;
  assign bist_busy  = busy_q;
  assign bist_done  = done_q;
  assign bist_fail  = fail_q;

endmodule

// File: tb/tb_arf062b064e1r1w0cbbehsaa4acw_bist_march_seq.sv
// Directed bench: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=4, each with an array model.
module tb_arf062b064e1r1w0cbbehsaa4acw_bist_march_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start    [2];
  logic [5:0]  addr     [2];
  logic        wr       [2];
  logic        rd       [2];
  logic [63:0] wd       [2];
  logic        busy     [2];
  logic        done     [2];
  logic        fail     [2];
`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN
  logic [5:0]  faddr    [2];
  logic [2:0]  felem    [2];
`endif
  logic        stuck_en [2];
  logic        late0_en [2];
  int          stuck_addr = 17;
  int          stuck_bit  = 5;

  int n_assert = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic [5:0]  la  [1001];
  logic        lr  [1001];
  logic        lw  [1001];
  logic [63:0] lwd [1001];
  logic        lb  [1001];
  logic        ld  [1001];
  logic        lf  [1001];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned Lat = (g == 0) ? 1 : 4;
    logic [63:0] mem [62];
    logic [63:0] rp  [4];
    logic [63:0] rdat;
    int          rd0_cnt;

    arf062b064e1r1w0cbbehsaa4acw_bist_march_seq #(
      .NUM_ENTRIES(62),
      .DATA_W     (64),
      .RD_LAT     (Lat)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .bist_start    (start[g]),
      .bist_rd_data  (rdat),
      .bist_addr     (addr[g]),
      .bist_wr_en    (wr[g]),
      .bist_rd_en    (rd[g]),
      .bist_wdata    (wd[g]),
      .bist_busy     (busy[g]),
      .bist_done     (done[g]),
`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN
      .bist_fail_addr(faddr[g]),
      .bist_fail_elem(felem[g]),
`endif
      .bist_fail     (fail[g])
    );

    // Array model with optional stuck-at-1 bit and a fault seen only on the 5th read of address 0.
    always @(posedge clk) begin
      logic [63:0] w;
      w = (addr[g] < 6'd62) ? mem[addr[g]] : 64'd0;
      if (stuck_en[g] && int'(addr[g]) == stuck_addr) w[stuck_bit] = 1'b1;
      if (late0_en[g] && addr[g] == 6'd0 && rd0_cnt == 4) w = ~w;
      if (wr[g] && addr[g] < 6'd62) mem[addr[g]] <= wd[g];
      if (start[g]) rd0_cnt <= 0;
      else if (rd[g] && addr[g] == 6'd0) rd0_cnt <= rd0_cnt + 1;
      rp[0] <= rd[g] ? w : 64'd0;
      for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
    end
    assign rdat = rp[Lat-1];
  end

  // Address bound and read/write exclusivity monitor.
  always @(negedge clk) begin
    if (!rst) begin
      viol <= viol + ((addr[0] >= 6'd62 || (rd[0] && wr[0])) ? 1 : 0)
                   + ((addr[1] >= 6'd62 || (rd[1] && wr[1])) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then log one sample per cycle (index 0 = first cycle after the start edge).
  task automatic run(input int g, input int mid_at, input int rst_at, output int n);
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    n = 0;
    while (n < 1000) begin
      la[n] = addr[g]; lr[n] = rd[g]; lw[n] = wr[g]; lwd[n] = wd[g];
      lb[n] = busy[g]; ld[n] = done[g]; lf[n] = fail[g];
      if (done[g]) break;
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_async_ctl", {busy[g], done[g], fail[g], rd[g], wr[g], addr[g]}, 64'd0);
        chk("rst_async_wdata", wd[g], 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        break;
      end
      start[g] = (n == mid_at);
      @(posedge clk);
      #1;
      n++;
    end
    start[g] = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    rst         = 1'b1;
    start[0]    = 1'b0;
    start[1]    = 1'b0;
    stuck_en[0] = 1'b0;
    stuck_en[1] = 1'b0;
    late0_en[0] = 1'b0;
    late0_en[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl_g0", {busy[0], done[0], fail[0], rd[0], wr[0], addr[0]}, 64'd0);
    chk("reset_wdata_g0", wd[0], 64'd0);
    chk("reset_ctl_g1", {busy[1], done[1], fail[1], rd[1], wr[1], addr[1]}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean run, RD_LAT=1.
    run(0, -1, -1, n);
    chk("first_w0_ctl", {lb[0], ld[0], lf[0], lr[0], lw[0], la[0]},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0});
    chk("first_w0_wdata", lwd[0], 64'd0);
    bad = 0;
    for (int i = 0; i < 62; i++) begin
      if (la[i] != 6'(i) || !lw[i] || lr[i] || lwd[i] != 64'd0) bad++;
    end
    chk("w0_walk", bad, 0);
    chk("r0w1u_first_read", {lr[62], lw[62], la[62]}, {1'b1, 1'b0, 6'd0});
    chk("r0w1u_first_write", {lw[63], la[63]}, {1'b1, 6'd0});
    chk("r0w1u_first_wdata", lwd[63], 64'hffff_ffff_ffff_ffff);
    chk("r0w1d_start_addr", {lr[310], lw[310], la[310]}, {1'b1, 1'b0, 6'd61});
    chk("r0d_last_read", {lr[619], lw[619], la[619]}, {1'b1, 1'b0, 6'd0});
    chk("drain_ctl", {lb[620], ld[620], lr[620], lw[620], la[620]},
        {1'b1, 1'b0, 1'b0, 1'b0, 6'd0});
    chk("clean_len", n, 621);
    chk("clean_end", {busy[0], done[0], fail[0]}, {1'b0, 1'b1, 1'b0});

    // Stuck-at-1 bit 5 at address 17.
    stuck_en[0] = 1'b1;
    run(0, -1, -1, n);
    chk("restart_done_clr", ld[0], 1'b0);
    chk("stuck_len", n, 621);
    chk("stuck_fail", {done[0], fail[0]}, {1'b1, 1'b1});
`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN
    chk("stuck_fail_addr", faddr[0], 6'd17);
    chk("stuck_fail_elem", felem[0], 3'd1);
`endif

    // Clean run after a failing one.
    stuck_en[0] = 1'b0;
    run(0, -1, -1, n);
    chk("rerun_first_clr", {ld[0], lf[0]}, {1'b0, 1'b0});
    chk("rerun_fail", {done[0], fail[0]}, {1'b1, 1'b0});
`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN
    chk("rerun_fail_addr", faddr[0], 6'd0);
`endif

    // Start pulsed while busy is ignored.
    run(0, 100, -1, n);
    chk("mid_start_len", n, 621);

    // Reset mid-run, then a full run.
    run(0, -1, 300, n);
    chk("after_rst_idle", {busy[0], done[0], fail[0]}, 64'd0);
    run(0, -1, -1, n);
    chk("post_rst_len", n, 621);
    chk("post_rst_fail", fail[0], 1'b0);

    // RD_LAT=4, fault only on the final R0_DN read of address 0.
    late0_en[1] = 1'b1;
    run(1, -1, -1, n);
    chk("lat4_len", n, 624);
    chk("lat4_fail_before", lf[623], 1'b0);
    chk("lat4_fail_at_done", {ld[n], lf[n]}, {1'b1, 1'b1});
`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN
    chk("lat4_fail_addr", faddr[1], 6'd0);
    chk("lat4_fail_elem", felem[1], 3'd5);
`endif

    chk("addr_bound_rw_excl", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/arf062b064e1r1w0cbbehsaa4acw_bist_march_seq.md
Name: arf062b064e1r1w0cbbehsaa4acw_bist_march_seq

Overview:
- March C- BIST sequencer for the 1R1W array.
- Generates the binary BIST address (fed directly to the bist_decoder for one-hot wordline select), the read/write enables and the background write data.
- Compares returned read data against the expected pattern after a fixed read latency.
- Reports busy, done and a sticky fail flag to the BIST controller.

Parameters:
- NUM_ENTRIES, 62, number of array entries; legal addresses 0..NUM_ENTRIES-1.
- ADDR_W, $clog2(NUM_ENTRIES), address width; must match the decoder IN_WIDTH.
- DATA_W, 64, array word width.
- RD_LAT, 1, cycles from bist_rd_en to valid bist_rd_data; legal range 1..4.

Ports:
- clk  in  1  array clock.
- rst  in  1  asynchronous, active-high reset.
- bist_start  in  1  start pulse; honoured only when idle.
- bist_rd_data  in  DATA_W  array read data, valid RD_LAT cycles after bist_rd_en.
- bist_addr  out  ADDR_W  registered address to the decoder and array.
- bist_wr_en  out  1  write enable.
- bist_rd_en  out  1  read enable.
- bist_wdata  out  DATA_W  background write data: all-0 or all-1.
- bist_busy  out  1  sequence in progress.
- bist_done  out  1  sequence complete; held until the next start.
- bist_fail  out  1  sticky miscompare flag.

Behaviour:
- Reset: all outputs 0; state IDLE; compare pipeline cleared. Reset asserted mid-run aborts immediately, with no done and no fail.
- All outputs are registered.
- bist_start sampled in IDLE or DONE at edge t:
  - bist_busy=1 from t+1.
  - bist_done and bist_fail cleared at t+1.
  - First W0 presented at t+1.
- bist_start while busy is ignored.
- State sequence: IDLE -> W0_UP -> R0W1_UP -> R1W0_UP -> R0W1_DN -> R1W0_DN -> R0_DN -> DRAIN -> DONE.
- UP elements walk addresses 0..NUM_ENTRIES-1. DN elements walk NUM_ENTRIES-1..0.
- The address never reaches values >= NUM_ENTRIES. The terminal address (NUM_ENTRIES-1 for UP, 0 for DN) triggers the state change on the same edge; no wrap-around.
- W0_UP and R0_DN: one operation per cycle per address.
- RxWy elements: two cycles per address.
  - Phase A: rd_en=1, expect x.
  - Phase B: wr_en=1, wdata=y, same address.
- rd_en and wr_en are never both 1.
- Total active cycles = 10*NUM_ENTRIES (620 at default).
- Compare pipeline: RD_LAT-deep shift register of {valid, expected}.
  - At depth RD_LAT, if valid and bist_rd_data != expected, bist_fail is set on the next edge.
  - bist_fail is sticky until the next accepted start or reset.
- DRAIN: busy held for RD_LAT cycles so that in-flight compares finish.
- DONE: bist_busy=0, bist_done=1.
- A failure on the final read in the drain window must still set bist_fail no later than the cycle bist_done rises.
- Outputs in IDLE/DRAIN/DONE: rd_en=0, wr_en=0, addr=0, wdata=0.

Optional Feature:
- Macro: ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CAPTURE_EN.
- When defined, two extra outputs are added:
  - bist_fail_addr [ADDR_W]
  - bist_fail_elem [2:0]: element code of the read, carried through the compare pipeline.
- These capture the first miscompare only; later fails do not overwrite them.
- Reset value 0; cleared on an accepted start.
- When not defined, the ports are absent and no capture flops are built.

Decomposition:
- Package arf062b064e1r1w0cbbehsaa4acw_bist_pkg holds:
  - the state enum (typedef bist_state_t);
  - the 3-bit element codes: W0U=0, R0W1U=1, R1W0U=2, R0W1D=3, R1W0D=4, R0D=5;
  - the all-0/all-1 pattern constants.
- One sub-module: arf062b064e1r1w0cbbehsaa4acw_bist_addr_cnt.
  - Up/down counter with load-to-start, enable and terminal-count outputs.
  - Parameterised by NUM_ENTRIES.

Test Plan:
- Reset then bist_start pulse, fault-free array model -> addr 0..61 written with 0 from cycle t+1; bist_done rises at t+1+620+RD_LAT; bist_fail=0.
- Address bound check: monitor over a full run -> bist_addr never reaches 62 or 63; the R0W1_DN element begins at address 61; rd_en and wr_en never both 1.
- Stuck-at-1 bit 5 at address 17 -> bist_fail=1; with the macro defined, fail_addr=17 and fail_elem=1 (first read expecting 0, in R0W1_UP).
- Fault on address 0 visible only in the final R0_DN read, RD_LAT=4 -> bist_fail set no later than the cycle bist_done rises.
- bist_start pulsed mid-run at cycle 100 -> ignored, sequence length unchanged. rst asserted at cycle 300 -> all outputs 0 asynchronously; a new start runs the full 620 cycles.
- Second start after a failing run -> bist_fail and bist_done cleared at t+1; clean array -> bist_fail stays 0.
